// File: rtl/i2c_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among N_REQ requesters.
// Optional watchdog abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk_400k,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*7-1:0]  req_slave_addr,
    input  logic [N_REQ-1:0]    req_rw,
    input  logic [N_REQ*8-1:0]  req_register_addr,
    input  logic [N_REQ*64-1:0] req_write_data,
    input  logic [N_REQ*3-1:0]  req_trans,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic [63:0]         rd_data,
    output logic                m_start,
    output logic [6:0]          m_slave_addr,
    output logic                m_rw,
    output logic [7:0]          m_register_addr,
    output logic [63:0]         m_write_data,
    output logic [2:0]          m_trans,
    input  logic [63:0]         m_read_data,
    input  logic                m_busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
        $error("i2c_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    logic [PW-1:0]    win;
    logic             found;
    int unsigned      idx;
    logic [N_REQ-1:0] win_onehot;
    logic [6:0]       sel_slave_addr;
    logic             sel_rw;
    logic [7:0]       sel_register_addr;
    logic [63:0]      sel_write_data;
    logic [2:0]       sel_trans;

    // First requesting index at or after ptr, then mux out its command fields.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_onehot        = '0;
        sel_slave_addr    = '0;
        sel_rw            = 1'b0;
        sel_register_addr = '0;
        sel_write_data    = '0;
        sel_trans         = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (win == PW'(j)) begin
                win_onehot[j]     = 1'b1;
                sel_slave_addr    = req_slave_addr[7*j +: 7];
                sel_rw            = req_rw[j];
                sel_register_addr = req_register_addr[8*j +: 8];
                sel_write_data    = req_write_data[64*j +: 64];
                sel_trans         = req_trans[3*j +: 3];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wdog;
    logic        wdog_expired;
    assign wdog_expired = (wdog == 16'(TIMEOUT_CYC - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_400k or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            gidx            <= '0;
            gnt             <= '0;
            done            <= '0;
            rd_data         <= '0;
            m_start         <= 1'b0;
            m_slave_addr    <= '0;
            m_rw            <= 1'b0;
            m_register_addr <= '0;
            m_write_data    <= '0;
            m_trans         <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err             <= 1'b0;
            wdog            <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt             <= win_onehot;
                        gidx            <= win;
                        m_slave_addr    <= sel_slave_addr;
                        m_rw            <= sel_rw;
                        m_register_addr <= sel_register_addr;
                        m_write_data    <= sel_write_data;
                        m_trans         <= sel_trans;
                        m_start         <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    m_start <= 1'b0;
                    state   <= WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog    <= '0;
`endif
                end
                WAIT_BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog <= wdog + 1'b1;
                    if (wdog_expired) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= COMPLETE;
                    end else
`endif
                    if (m_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog <= wdog + 1'b1;
                    if (wdog_expired) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= COMPLETE;
                    end else
`endif
                    if (!m_busy) begin
                        done  <= gnt;
                        state <= COMPLETE;
                        if (m_rw) begin
                            rd_data <= m_read_data;
                        end
                    end
                end
                COMPLETE: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                    if (gidx == PW'(N_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gidx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed cases plus randomized traffic
// against a transaction-level round-robin model and a simple master model.
module tb_i2c_arbiter;

    localparam int N = 4;

    logic clk_400k = 1'b0;
    always #5 clk_400k = ~clk_400k;

    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  req_rw;
    logic [6:0]    sa [N];
    logic [7:0]    ra [N];
    logic [63:0]   wd [N];
    logic [2:0]    tr [N];
    logic [N*7-1:0]  req_slave_addr;
    logic [N*8-1:0]  req_register_addr;
    logic [N*64-1:0] req_write_data;
    logic [N*3-1:0]  req_trans;

    logic [N-1:0] gnt, done;
    logic         err, m_start, m_rw, m_busy;
    logic [63:0]  rd_data, m_write_data, m_read_data;
    logic [6:0]   m_slave_addr;
    logic [7:0]   m_register_addr;
    logic [2:0]   m_trans;

    always_comb begin
        req_slave_addr    = '0;
        req_register_addr = '0;
        req_write_data    = '0;
        req_trans         = '0;
        for (int i = 0; i < N; i++) begin
            req_slave_addr[7*i +: 7]     = sa[i];
            req_register_addr[8*i +: 8]  = ra[i];
            req_write_data[64*i +: 64]   = wd[i];
            req_trans[3*i +: 3]          = tr[i];
        end
    end

    i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk_400k(clk_400k), .rst_n(rst_n), .req(req),
        .req_slave_addr(req_slave_addr), .req_rw(req_rw),
        .req_register_addr(req_register_addr), .req_write_data(req_write_data),
        .req_trans(req_trans), .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .m_start(m_start), .m_slave_addr(m_slave_addr), .m_rw(m_rw),
        .m_register_addr(m_register_addr), .m_write_data(m_write_data),
        .m_trans(m_trans), .m_read_data(m_read_data), .m_busy(m_busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          phase;      // 0 free, 1 transaction active, 2 returning to idle
    int          cur;
    int          ptr_m;
    logic [6:0]  c_sa;
    logic        c_rw;
    logic [7:0]  c_ra;
    logic [63:0] c_wd;
    logic [2:0]  c_tr;
    logic [63:0] exp_rd;
    bit          seen_busy;
    int          grant_log[$];

    // Master model and requester policy
    int          mwait, mlen;
    bit          use_forced;
    logic [63:0] forced_rd;
    int          raise_pct;
    bit          chaos;
    bit          dropped [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0; cur = 0; ptr_m = 0; seen_busy = 0;
        c_sa = '0; c_rw = 1'b0; c_ra = '0; c_wd = '0; c_tr = '0;
        exp_rd = '0; mwait = 0; mlen = 0; m_busy = 1'b0;
        for (int i = 0; i < N; i++) dropped[i] = 1'b0;
    endtask

    task automatic raise(input int i);
        req[i]    = 1'b1;
        sa[i]     = 7'($urandom);
        req_rw[i] = 1'($urandom);
        ra[i]     = 8'($urandom);
        wd[i]     = {$urandom, $urandom};
        tr[i]     = 3'($urandom);
    endtask

    task automatic step();
        logic [N-1:0] exp_gnt, exp_done;
        bit start_exp, active, just_done;
        int w;
        @(negedge clk_400k);
        exp_done = '0; start_exp = 0; active = 0; just_done = 0; w = -1;
        case (phase)
            0: if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
                end
                cur = w; c_sa = sa[w]; c_rw = req_rw[w]; c_ra = ra[w]; c_wd = wd[w]; c_tr = tr[w];
                grant_log.push_back(w);
                phase = 1; seen_busy = 0; start_exp = 1; active = 1;
            end
            1: begin
                active = 1;
                if (seen_busy && !m_busy) begin
                    exp_done[cur] = 1'b1;
                    if (c_rw) exp_rd = m_read_data;
                    ptr_m = (cur + 1) % N;
                    phase = 2; just_done = 1;
                end else if (m_busy) begin
                    seen_busy = 1;
                end
            end
            default: phase = 0;
        endcase
        exp_gnt = active ? (N'(1) << cur) : '0;
        check("gnt", gnt, exp_gnt);
        check("done", done, exp_done);
        check("err", err, 0);
        check("m_start", m_start, start_exp);
        check("rd_data", rd_data, exp_rd);
        check("m_write_data", m_write_data, c_wd);
        check("m_cmd", {m_slave_addr, m_rw, m_register_addr, m_trans}, {c_sa, c_rw, c_ra, c_tr});

        if (start_exp) begin
            mwait = $urandom_range(1, 3);
            mlen  = $urandom_range(1, 5);
        end else if (mwait > 0) begin
            mwait--;
            if (mwait == 0) begin
                m_busy = 1'b1;
                m_read_data = use_forced ? forced_rd : {$urandom, $urandom};
            end
        end else if (m_busy) begin
            mlen--;
            if (mlen == 0) m_busy = 1'b0;
        end

        if (just_done) begin
            req[cur] = 1'b0;
            dropped[cur] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (just_done && i == cur) continue;
            if (phase == 1 && i == cur) begin
                if (chaos && $urandom_range(7) == 0) wd[i] = {$urandom, $urandom};
                if (chaos && req[i] && $urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                    dropped[i] = 1'b1;
                end
            end else if (!req[i] && !dropped[i] && raise_pct > 0 && $urandom_range(99) < raise_pct) begin
                raise(i);
            end
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while (!(phase == 0 && req == '0 && !m_busy && mwait == 0) && n < budget) begin
            step();
            n++;
        end
        check("wait_bound", n < budget, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        rst_n = 1'b0; req = '0; req_rw = '0; m_read_data = '0;
        for (int i = 0; i < N; i++) begin sa[i] = '0; ra[i] = '0; wd[i] = '0; tr[i] = '0; end
        raise_pct = 0; chaos = 0; use_forced = 0; forced_rd = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write from requester 0
        sa[0] = 7'h50; ra[0] = 8'h10; wd[0] = 64'h11; req_rw[0] = 1'b0; tr[0] = 3'd1;
        req[0] = 1'b1;
        wait_quiet(60);
        check("write_rd_zero", rd_data, 64'h0);

        // Read from requester 2 with a known master payload
        use_forced = 1; forced_rd = 64'hDEADBEEF_CAFEF00D;
        sa[2] = 7'h21; ra[2] = 8'h05; wd[2] = '0; req_rw[2] = 1'b1; tr[2] = 3'd4;
        req[2] = 1'b1;
        wait_quiet(60);
        check("read_rd", rd_data, 64'hDEADBEEF_CAFEF00D);
        use_forced = 0;

        // Reset while waiting for the master to finish
        raise(3);
        n = 0;
        while (!(phase == 1 && seen_busy) && n < 40) begin step(); n++; end
        check("reach_wait_done", n < 40, 1);
        rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_flags", {err, m_start, m_rw}, 0);
        check("rst_rd", rd_data, 0);
        check("rst_cmd", {m_slave_addr, m_register_addr, m_trans}, 0);
        check("rst_wd", m_write_data, 0);
        req = '0;
        model_reset();
        step();
        rst_n = 1'b1;
        raise(1);
        raise(3);
        grant_log.delete();
        wait_quiet(100);
        check("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

        // Full contention, re-raised after each completion
        raise_pct = 100;
        grant_log.delete();
        for (int i = 0; i < N; i++) raise(i);
        n = 0;
        while (grant_log.size() < 5 && n < 300) begin step(); n++; end
        raise_pct = 0;
        wait_quiet(200);
        check("rr_count", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("rr_order", grant_log[i], i % N);
        end

        // Random traffic: drops while granted and field changes after capture
        raise_pct = 30; chaos = 1;
        repeat (3000) step();
        raise_pct = 0; chaos = 0;
        wait_quiet(200);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never answers: watchdog must abort 16 cycles into WAIT_BUSY
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk_400k); n++; end while (!m_start && n < 20);
        check("to_start", m_start, 1);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_400k);
            check("to_done", done, (c == 17) ? 1 : 0);
            check("to_err", err, (c == 17) ? 1 : 0);
        end
        check("to_rd", rd_data, exp_rd);
        req[0] = 1'b0;
        @(negedge clk_400k);
        check("to_after", {gnt, done, err}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
